// File: rtl/ctl_reg_reader.sv
// rtl/ctl_reg_reader.sv - controller BRAM poller: publishes version/state, streams requested register groups
module ctl_reg_reader #(
    parameter int         BramLatency  = 2,
    parameter logic [7:0] VersionMajor = 8'h91,
    parameter logic [7:0] VersionMinor = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        BRAM_EN,
    output logic        BRAM_WE,
    output logic [7:0]  BRAM_ADDR,
    output logic [15:0] BRAM_DIN,
    input  logic [15:0] BRAM_DOUT,
    input  logic [6:0]  FPGA_STATE_IN,
    input  logic        READS_FPGA_STATE_EN,
    output logic        REG_VALID,
    output logic [7:0]  REG_ADDR,
    output logic [15:0] REG_DATA,
    output logic        SET_DONE,
    output logic [2:0]  SET_GROUP,
    output logic        FORCE_FAN,
    output logic        BUSY
);

    typedef enum logic [3:0] {
        S_INIT_MAJ, S_INIT_MIN, S_STATE_WR, S_POLL_REQ, S_POLL_WAIT, S_DISPATCH,
        S_GRP_RD, S_GRP_DRAIN, S_FLAG_RD, S_FLAG_WAIT, S_FLAG_WR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] flag_q, flag_d;
    logic        fan_q, fan_d;
    logic [2:0]  grp_q, grp_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  end_q, end_d;

    logic [BramLatency-1:0] vld_q;
    logic [7:0]             apipe_q [BramLatency];

    logic        en_c, we_c, issue_c, done_c;
    logic [7:0]  a_c;
    logic [15:0] din_c;
    logic [2:0]  sel_c;
    logic        wait_last_c;

    assign wait_last_c = (cnt_q == 2'(BramLatency - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        fan_d   = fan_q;
        grp_d   = grp_q;
        addr_d  = addr_q;
        end_d   = end_q;
        en_c    = 1'b0;
        we_c    = 1'b0;
        a_c     = 8'h00;
        din_c   = 16'h0000;
        issue_c = 1'b0;
        done_c  = 1'b0;
        sel_c   = 3'd0;
        // Scan downward so the lowest set request bit wins.
        for (int i = 5; i >= 0; i--) begin
            if (flag_q[i]) sel_c = 3'(i);
        end
        case (state_q)
            S_INIT_MAJ: begin
                en_c = 1'b1; we_c = 1'b1; a_c = 8'h02;
                din_c = {8'h00, VersionMajor};
                state_d = S_INIT_MIN;
            end
            S_INIT_MIN: begin
                en_c = 1'b1; we_c = 1'b1; a_c = 8'h03;
                din_c = {8'h00, VersionMinor};
                state_d = S_STATE_WR;
            end
            S_STATE_WR: begin
                en_c = 1'b1; we_c = 1'b1; a_c = 8'h01;
                din_c = {8'h00, READS_FPGA_STATE_EN, FPGA_STATE_IN};
                state_d = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                en_c = 1'b1; a_c = 8'h00; cnt_d = 2'd0;
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT, S_FLAG_WAIT: begin
                if (wait_last_c) begin
                    flag_d  = BRAM_DOUT;
                    fan_d   = BRAM_DOUT[13];
                    state_d = (state_q == S_POLL_WAIT) ? S_DISPATCH : S_FLAG_WR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DISPATCH: begin
                if (flag_q[5:0] == 6'd0) begin
                    state_d = S_STATE_WR;
                end else begin
                    grp_d   = sel_c;
                    state_d = S_GRP_RD;
                    case (sel_c)
                        3'd0:    begin addr_d = 8'h20; end_d = 8'h30; end
                        3'd1:    begin addr_d = 8'h50; end_d = 8'h68; end
                        3'd2:    begin addr_d = 8'h40; end_d = 8'h44; end
                        3'd3:    begin addr_d = 8'hE0; end_d = 8'hE1; end
                        3'd4:    begin addr_d = 8'hF0; end_d = 8'hF7; end
                        default: begin addr_d = 8'h10; end_d = 8'h13; end
                    endcase
                end
            end
            S_GRP_RD: begin
                en_c = 1'b1; a_c = addr_q; issue_c = 1'b1;
                if (addr_q == end_q) state_d = S_GRP_DRAIN;
                else                 addr_d  = addr_q + 8'd1;
            end
            S_GRP_DRAIN: begin
                // Pipeline empty means the last strobe was the previous cycle.
                if (vld_q == '0) begin
                    done_c  = 1'b1;
                    state_d = S_FLAG_RD;
                end
            end
            S_FLAG_RD: begin
                en_c = 1'b1; a_c = 8'h00; cnt_d = 2'd0;
                state_d = S_FLAG_WAIT;
            end
            S_FLAG_WR: begin
                en_c = 1'b1; we_c = 1'b1; a_c = 8'h00;
                din_c = flag_q & ~(16'h0001 << grp_q);
                state_d = S_STATE_WR;
            end
            default: state_d = S_INIT_MAJ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_INIT_MAJ;
            cnt_q   <= 2'd0;
            flag_q  <= 16'h0000;
            fan_q   <= 1'b0;
            grp_q   <= 3'd0;
            addr_q  <= 8'h00;
            end_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            fan_q   <= fan_d;
            grp_q   <= grp_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
        end
    end

    // Read-tracking pipeline: each issued group read reappears BramLatency cycles later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
            for (int i = 0; i < BramLatency; i++) apipe_q[i] <= 8'h00;
        end else begin
            vld_q[0]   <= issue_c;
            apipe_q[0] <= a_c;
            for (int i = 1; i < BramLatency; i++) begin
                vld_q[i]   <= vld_q[i-1];
                apipe_q[i] <= apipe_q[i-1];
            end
        end
    end

    // Outputs are forced low while reset is held so an abort is visible at once.
    assign BRAM_EN   = en_c & ~RST;
    assign BRAM_WE   = we_c & ~RST;
    assign BRAM_ADDR = RST ? 8'h00 : a_c;
    assign BRAM_DIN  = (we_c & ~RST) ? din_c : 16'h0000;
    assign REG_VALID = vld_q[BramLatency-1] & ~RST;
    assign REG_ADDR  = REG_VALID ? apipe_q[BramLatency-1] : 8'h00;
    assign REG_DATA  = REG_VALID ? BRAM_DOUT : 16'h0000;
    assign SET_DONE  = done_c & ~RST;
    assign SET_GROUP = SET_DONE ? grp_q : 3'd0;
    assign FORCE_FAN = fan_q & ~RST;
    assign BUSY      = (state_q != S_POLL_REQ) & ~RST;

endmodule

// File: tb/tb_ctl_reg_reader.sv
// tb/tb_ctl_reg_reader.sv - scoreboard bench for ctl_reg_reader with a BRAM model and host port
module tb_ctl_reg_reader;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bram_en, bram_we;
    logic [7:0]  bram_addr;
    logic [15:0] bram_din, bram_dout;
    logic [6:0]  fpga_state = 7'h15;
    logic        rd_state_en = 1'b1;
    logic        reg_valid, set_done, force_fan, busy;
    logic [7:0]  reg_addr;
    logic [15:0] reg_data;
    logic [2:0]  set_group;

    always #5 clk = ~clk;

    ctl_reg_reader #(.BramLatency(L), .VersionMajor(8'h91), .VersionMinor(8'h00)) dut (
        .CLK(clk), .RST(rst),
        .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_ADDR(bram_addr),
        .BRAM_DIN(bram_din), .BRAM_DOUT(bram_dout),
        .FPGA_STATE_IN(fpga_state), .READS_FPGA_STATE_EN(rd_state_en),
        .REG_VALID(reg_valid), .REG_ADDR(reg_addr), .REG_DATA(reg_data),
        .SET_DONE(set_done), .SET_GROUP(set_group),
        .FORCE_FAN(force_fan), .BUSY(busy)
    );

    logic [15:0] mem [256];
    logic [15:0] rd_pipe [L];
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = 8'h00;
    logic [15:0] host_din = 16'h0000;

    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_din;
        if (bram_en && bram_we) mem[bram_addr] <= bram_din;
        rd_pipe[0] <= mem[bram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[L-1];

    typedef struct { logic [7:0] a; logic [15:0] d; } reg_t;
    typedef struct { logic [2:0] g; int n; } done_t;
    reg_t        exp_q [$];
    done_t       done_q [$];
    logic [15:0] flagw_q [$];

    int tests = 0, fails = 0;
    int run_len = 0, strobes = 0, ver_cnt = 0, st_cnt = 0;
    logic prev_valid = 1'b0, check_fan = 1'b0;
    logic [15:0] exp_state = 16'h0095;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            prev_valid = 1'b0;
        end else begin
            if (reg_valid) begin
                strobes++;
                run_len = prev_valid ? run_len + 1 : 1;
                if (exp_q.size() == 0) begin
                    chk("reg_extra_strobe", {24'h0, reg_addr}, 32'hFFFF_FFFF);
                end else begin
                    reg_t e;
                    e = exp_q.pop_front();
                    chk("reg_addr", {24'h0, reg_addr}, {24'h0, e.a});
                    chk("reg_data", {16'h0, reg_data}, {16'h0, e.d});
                end
                if (check_fan) chk("force_fan_stream", {31'h0, force_fan}, 32'h1);
            end
            if (set_done) begin
                if (done_q.size() == 0) begin
                    chk("set_done_extra", {29'h0, set_group}, 32'hFFFF_FFFF);
                end else begin
                    done_t dn;
                    dn = done_q.pop_front();
                    chk("set_group", {29'h0, set_group}, {29'h0, dn.g});
                    chk("group_run_len", run_len, dn.n);
                    chk("done_after_last", {31'h0, prev_valid}, 32'h1);
                end
            end
            if (bram_en && bram_we) begin
                case (bram_addr)
                    8'h00: begin
                        if (flagw_q.size() == 0) chk("flag_wr_extra", {16'h0, bram_din}, 32'hFFFF_FFFF);
                        else chk("flag_wr", {16'h0, bram_din}, {16'h0, flagw_q.pop_front()});
                    end
                    8'h01: begin st_cnt++; chk("state_wr", {16'h0, bram_din}, {16'h0, exp_state}); end
                    8'h02: begin ver_cnt++; chk("ver_major", {16'h0, bram_din}, 32'h0091); end
                    8'h03: chk("ver_minor", {16'h0, bram_din}, 32'h0000);
                    default: chk("wr_bad_addr", {24'h0, bram_addr}, 32'hFFFF_FFFF);
                endcase
            end else begin
                chk("din_idle", {15'h0, bram_we, bram_din}, 32'h0);
            end
            prev_valid = reg_valid;
        end
    end

    task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_din = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic push_grp(input logic [2:0] g, input logic [7:0] lo, input logic [7:0] hi);
        for (int a = lo; a <= hi; a++) begin
            reg_t e;
            e.a = 8'(a);
            e.d = mem[a];
            exp_q.push_back(e);
        end
        done_q.push_back('{g: g, n: hi - lo + 1});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || flagw_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size() + done_q.size() + flagw_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n, s0, v0, c0;
        @(negedge clk);
        host_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            host_addr = 8'(i);
            host_din  = (i == 0) ? 16'h0000 : {8'(~i), 8'(i)};
            @(negedge clk);
        end
        host_we = 1'b0;
        chk("reset_outputs", {bram_en, bram_we, bram_addr, bram_din[5:0], reg_valid, reg_addr[7:0],
                              set_done, set_group, force_fan, busy}, 32'h0);
        chk("reset_data", {bram_din, reg_data}, 32'h0);

        rst = 1'b0;
        #1 chk("first_wr_major", {bram_en, bram_we, 6'h0, bram_addr, bram_din}, {8'hC0, 8'h02, 16'h0091});
        @(negedge clk);
        chk("second_wr_minor", {bram_en, bram_we, 6'h0, bram_addr, bram_din}, {8'hC0, 8'h03, 16'h0000});
        @(negedge clk);
        chk("third_wr_state", {bram_en, bram_we, 6'h0, bram_addr, bram_din}, {8'hC0, 8'h01, 16'h0095});
        @(negedge clk);
        chk("poll_read", {bram_en, bram_we, 6'h0, bram_addr, 15'h0, busy}, {8'h80, 8'h00, 16'h0000});
        @(negedge clk);
        chk("busy_after_poll", {31'h0, busy}, 32'h1);
        s0 = strobes; c0 = st_cnt;
        repeat (30) @(negedge clk);
        chk("idle_no_strobe", strobes - s0, 0);
        chk("idle_state_rewrites", {31'h0, (st_cnt - c0) >= 3}, 32'h1);

        push_grp(3'd2, 8'h40, 8'h44);
        flagw_q.push_back(16'h0000);
        host_wr(8'h00, 16'h0004);
        wait_idle("silencer_done", 200);
        chk("silencer_flag_mem", {16'h0, mem[0]}, 32'h0000);

        push_grp(3'd0, 8'h20, 8'h30);
        flagw_q.push_back(16'h2002);
        push_grp(3'd1, 8'h50, 8'h68);
        flagw_q.push_back(16'h2000);
        check_fan = 1'b1;
        host_wr(8'h00, 16'h2003);
        wait_idle("mod_stm_done", 400);
        check_fan = 1'b0;
        chk("fan_after_groups", {31'h0, force_fan}, 32'h1);
        chk("mod_stm_flag_mem", {16'h0, mem[0]}, 32'h2000);
        host_wr(8'h00, 16'h0000);
        repeat (20) @(negedge clk);
        chk("fan_cleared", {31'h0, force_fan}, 32'h0);

        @(posedge clk);
        #1 fpga_state = 7'h2A; rd_state_en = 1'b0; exp_state = 16'h002A;
        c0 = st_cnt;
        repeat (30) @(negedge clk);
        chk("state_wr_changed", {31'h0, (st_cnt - c0) >= 3}, 32'h1);

        push_grp(3'd0, 8'h20, 8'h30);
        flagw_q.push_back(16'h0020);
        push_grp(3'd5, 8'h10, 8'h13);
        flagw_q.push_back(16'h0000);
        host_wr(8'h00, 16'h0001);
        n = 0;
        while (exp_q.size() > 15 && n < 200) begin @(negedge clk); n++; end
        chk("race_stream_started", {31'h0, exp_q.size() <= 15}, 32'h1);
        host_wr(8'h00, 16'h0021);
        wait_idle("race_done", 300);
        chk("race_flag_mem", {16'h0, mem[0]}, 32'h0000);

        push_grp(3'd1, 8'h50, 8'h68);
        host_wr(8'h00, 16'h0002);
        n = 0;
        while (exp_q.size() > 15 && n < 200) begin @(negedge clk); n++; end
        chk("rst_stream_started", {31'h0, exp_q.size() <= 15}, 32'h1);
        rst = 1'b1;
        exp_q.delete(); done_q.delete(); flagw_q.delete();
        @(negedge clk);
        chk("midrst_outputs", {bram_en, bram_we, bram_addr, bram_din[5:0], reg_valid, reg_addr[7:0],
                               set_done, set_group, force_fan, busy}, 32'h0);
        chk("midrst_data", {bram_din, reg_data}, 32'h0);
        @(negedge clk);
        chk("midrst_flag_kept", {16'h0, mem[0]}, 32'h0002);
        v0 = ver_cnt;
        push_grp(3'd1, 8'h50, 8'h68);
        flagw_q.push_back(16'h0000);
        rst = 1'b0;
        wait_idle("restart_stm_done", 300);
        chk("restart_version_rewritten", ver_cnt - v0, 1);
        chk("restart_flag_mem", {16'h0, mem[0]}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ctl_reg_reader.md
Name: ctl_reg_reader

Overview:
- Reader/responder for the host-written controller BRAM (BRAM_SELECT_CONTROLLER, 256 x 16-bit words). It owns the FPGA-side port of that BRAM.
- It polls ADDR_CTL_FLAG and, for each set request bit, streams the corresponding register group out to downstream config latches.
- After a group has been streamed, it clears the request bit. It also writes back the version words and FPGA state.

Parameters:
BramLatency, 2, cycles from BRAM_ADDR/BRAM_EN to valid BRAM_DOUT (supported: 1..3)
VersionMajor, 8'h91, value written to ADDR_VERSION_NUM_MAJOR
VersionMinor, 8'h00, value written to ADDR_VERSION_NUM_MINOR

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
BRAM_EN  out  1  port enable
BRAM_WE  out  1  write enable (valid with BRAM_EN)
BRAM_ADDR  out  8  word address
BRAM_DIN  out  16  write data
BRAM_DOUT  in  16  read data
FPGA_STATE_IN  in  7  status bits [6:0] to publish
READS_FPGA_STATE_EN  in  1  published as FPGA_STATE bit 7
REG_VALID  out  1  one-cycle strobe, REG_ADDR/REG_DATA valid
REG_ADDR  out  8  address of streamed register
REG_DATA  out  16  data of streamed register
SET_DONE  out  1  one-cycle pulse after last REG_VALID of a group
SET_GROUP  out  3  ctl_flag_bit index of completed group (valid with SET_DONE)
FORCE_FAN  out  1  CTL_FLAG bit 13 from most recent flag read
BUSY  out  1  high outside POLL_REQ

Behaviour:
- Reset values: all outputs 0; FSM enters INIT_MAJ. RST mid-operation aborts any group immediately: no SET_DONE, no flag write, restarts at INIT_MAJ.
- INIT_MAJ: write {8'h00,VersionMajor} to 0x02.
- INIT_MIN: write {8'h00,VersionMinor} to 0x03, then go to STATE_WR.
- STATE_WR: write {8'h00, READS_FPGA_STATE_EN, FPGA_STATE_IN} to 0x01, then go to POLL_REQ.
- POLL_REQ: read 0x00. POLL_WAIT holds for BramLatency cycles, then the flag word is captured and FORCE_FAN is updated.
- DISPATCH: select the lowest set bit among 0..5. If none is set, go to STATE_WR.
- Group ranges are contiguous and inclusive:
  - bit0 MOD: 0x20..0x30
  - bit1 STM: 0x50..0x68 (0x53 included)
  - bit2 SILENCER: 0x40..0x44
  - bit3 PWE: 0xE0..0xE1
  - bit4 DEBUG: 0xF0..0xF7
  - bit5 SYNC: 0x10..0x13
- GRP_RD: issue one read per cycle, ascending, with no bubbles. Each REG_VALID fires exactly BramLatency cycles after its address and carries that address and the returned data. N registers produce N consecutive REG_VALID cycles.
- GRP_DRAIN: wait for the last read to return. SET_DONE is asserted the cycle after the last REG_VALID, with SET_GROUP equal to the bit index.
- FLAG_RD: re-read 0x00 and wait BramLatency cycles.
- FLAG_WR: write (fresh value & ~(1<<bit)). Other bits are preserved from the re-read. Host writes landing between re-read data and FLAG_WR (1 cycle) are lost; this is an accepted race. Then go to STATE_WR.
- One group per poll iteration. A host re-setting a bit during its group's streaming is cleared by FLAG_WR; the host must poll the bit.
- Bits 6..12 and 14..15 are ignored and never modified except by passthrough in FLAG_WR.
- BRAM_EN is high only on cycles issuing a read or write. BRAM_WE is high only in INIT_MAJ, INIT_MIN, STATE_WR, FLAG_WR. BRAM_DIN is 0 when not writing.
- Address counter: 8-bit; never wraps (max 0xF7). REG_ADDR tracking uses a BramLatency-deep shift pipeline.

Test Plan:
- Reset release, BramLatency=2 -> writes 0x0091@0x02, 0x0000@0x03, then FPGA_STATE write, then read of 0x00; no REG_VALID.
- CTL_FLAG=0x0004 -> five REG_VALID at 0x40..0x44 on consecutive cycles with BRAM contents; SET_DONE with SET_GROUP=2 next cycle; 0x00 becomes 0x0000.
- CTL_FLAG=0x2003 -> MOD group (17 strobes) and SET_DONE group 0, flag written 0x2002; next poll STM group (25 strobes incl. 0x53), flag 0x2000; FORCE_FAN=1 throughout.
- FPGA_STATE_IN=7'h15, READS_FPGA_STATE_EN=1, no flags -> 0x01 repeatedly written 0x0095.
- Host sets bit 5 while MOD group is streaming (bit0 set) -> FLAG_WR writes 0x0020; SYNC group (0x10..0x13) streams next iteration.
- RST asserted mid-STM group -> all outputs 0 next cycle, no SET_DONE, flag bit remains set, sequence restarts with version writes then STM group re-streamed from 0x50.
